// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter: FSM state encoding and
// counter saturation value.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } pm_state_e;

  // All-ones value of a w-bit counter; the period counter times out here.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/period_meter_edge_sync.sv
// Input conditioning for the period meter: optional 2-flop synchronizer
// (PERIOD_METER_SYNC_EN), one-cycle delayed copy and rising-edge pulse.
module period_meter_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic s_r;
  logic s_d_r;

`ifdef PERIOD_METER_SYNC_EN
  logic meta_r;

  // Two-flop synchronizer for asynchronous sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      s_r    <= 1'b0;
    end else begin
      meta_r <= sig_in;
      s_r    <= meta_r;
    end
  end
`else
  // Single sampling register; sig_in is already synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r <= 1'b0;
    end else begin
      s_r <= sig_in;
    end
  end
`endif

  // Delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_r <= 1'b0;
    end else begin
      s_d_r <= s_r;
    end
  end

  assign s    = s_r;
  assign rise = s_r & ~s_d_r;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of sig_in in clk cycles, with lock and
// timeout status. Define PERIOD_METER_SYNC_EN for asynchronous sig_in.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] EXP_P      = CNT_W'(EXP_PERIOD);
  localparam logic [MW-1:0]    MATCH_FULL = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    MATCH_ZERO = MW'(0);
  localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);

  logic s_s;
  logic rise_s;

  pm_state_e        state_r,   state_nx_s;
  logic [CNT_W-1:0] cnt_r,     cnt_nx_s;
  logic [CNT_W-1:0] hcnt_r,    hcnt_nx_s;
  logic [MW-1:0]    match_r,   match_nx_s;
  logic [CNT_W-1:0] period_r,  period_nx_s;
  logic [CNT_W-1:0] high_r,    high_nx_s;
  logic             valid_r,   valid_nx_s;
  logic             locked_r,  locked_nx_s;
  logic             timeout_r, timeout_nx_s;

  period_meter_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (reset),
    .sig_in (sig_in),
    .s      (s_s),
    .rise   (rise_s)
  );

  // Next-state and next-output computation for the measurement FSM.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    hcnt_nx_s    = hcnt_r;
    match_nx_s   = match_r;
    period_nx_s  = period_r;
    high_nx_s    = high_r;
    valid_nx_s   = 1'b0;
    locked_nx_s  = locked_r;
    timeout_nx_s = timeout_r;

    if (!enable) begin
      state_nx_s   = IDLE;
      cnt_nx_s     = CNT_ZERO;
      hcnt_nx_s    = CNT_ZERO;
      match_nx_s   = MATCH_ZERO;
      locked_nx_s  = 1'b0;
      timeout_nx_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s   = ARM;
          cnt_nx_s     = CNT_ZERO;
          hcnt_nx_s    = CNT_ZERO;
          match_nx_s   = MATCH_ZERO;
          locked_nx_s  = 1'b0;
          timeout_nx_s = 1'b0;
        end
        ARM: begin
          if (rise_s) begin
            state_nx_s = MEASURE;
            cnt_nx_s   = CNT_ONE;
            hcnt_nx_s  = CNT_ONE;
          end else begin
            cnt_nx_s   = CNT_ZERO;
            hcnt_nx_s  = CNT_ZERO;
          end
        end
        MEASURE: begin
          // An edge coinciding with saturation is still a valid measurement.
          if (rise_s) begin
            period_nx_s  = cnt_r;
            high_nx_s    = hcnt_r;
            valid_nx_s   = 1'b1;
            timeout_nx_s = 1'b0;
            cnt_nx_s     = CNT_ONE;
            hcnt_nx_s    = CNT_ONE;
            if (cnt_r != EXP_P) begin
              match_nx_s = MATCH_ZERO;
            end else if (match_r == MATCH_FULL) begin
              match_nx_s = match_r;
            end else begin
              match_nx_s = match_r + MATCH_ONE;
            end
            locked_nx_s = (match_nx_s == MATCH_FULL);
          end else if (cnt_r == CNT_MAX) begin
            state_nx_s   = ARM;
            timeout_nx_s = 1'b1;
            locked_nx_s  = 1'b0;
            match_nx_s   = MATCH_ZERO;
            cnt_nx_s     = CNT_ZERO;
            hcnt_nx_s    = CNT_ZERO;
          end else begin
            cnt_nx_s  = cnt_r + CNT_ONE;
            hcnt_nx_s = hcnt_r + CNT_W'(s_s);
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Counters, match tracker and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= CNT_ZERO;
      hcnt_r    <= CNT_ZERO;
      match_r   <= MATCH_ZERO;
      period_r  <= CNT_ZERO;
      high_r    <= CNT_ZERO;
      valid_r   <= 1'b0;
      locked_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nx_s;
      hcnt_r    <= hcnt_nx_s;
      match_r   <= match_nx_s;
      period_r  <= period_nx_s;
      high_r    <= high_nx_s;
      valid_r   <= valid_nx_s;
      locked_r  <= locked_nx_s;
      timeout_r <= timeout_nx_s;
    end
  end

  assign period     = period_r;
  assign high_time  = high_r;
  assign meas_valid = valid_r;
  assign locked     = locked_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter (CNT_W=8): directed waveforms push
// expected measurements; a monitor compares them on every meas_valid.
module tb_period_meter;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  typedef struct {
    int per;
    int hi;
    int lk;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  period_meter #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (10),
    .LOCK_CNT   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One waveform period; optionally queue the result its rising edge closes.
  task automatic cyc(input int hi, input int lo, input bit push,
                     input int eper, input int ehi, input int elk);
    exp_t e;
    if (push) begin
      e.per = eper;
      e.hi  = ehi;
      e.lk  = elk;
      sb_q.push_back(e);
    end
    sig_in = 1'b1;
    repeat (hi) tick();
    sig_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic drain(input string name);
    repeat (4) tick();
    chk(name, sb_q.size(), 0);
  endtask

  // Monitor: every meas_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_meas_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("period", period, e.per);
        chk("high_time", high_time, e.hi);
        chk("locked", locked, e.lk);
        chk("timeout_at_valid", timeout, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_to;
    clk    = 1'b0;
    reset  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    #12;
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    tick();
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) tick();

    // Divide-by-10, 5 high / 5 low: lock on the 4th measurement.
    cyc(5, 5, 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(5, 5, 1'b1, 10, 5, 0);
    for (int i = 0; i < 2; i++) cyc(5, 5, 1'b1, 10, 5, 1);

    // One 11-cycle period drops lock; four good periods restore it.
    cyc(6, 5, 1'b1, 10, 5, 1);
    cyc(5, 5, 1'b1, 11, 6, 0);
    for (int i = 0; i < 3; i++) cyc(5, 5, 1'b1, 10, 5, 0);
    cyc(5, 5, 1'b1, 10, 5, 1);

    // Enable dropped mid-period: no result, values retained, lock cleared.
    enable = 1'b0;
    repeat (3) tick();
    chk("dis_period", period, 10);
    chk("dis_high_time", high_time, 5);
    chk("dis_locked", locked, 0);
    chk("dis_timeout", timeout, 0);
    drain("drain_div10");

    // Asymmetric 3 high / 7 low after re-enable.
    enable = 1'b1;
    repeat (3) tick();
    cyc(3, 7, 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(3, 7, 1'b1, 10, 3, 0);
    cyc(3, 7, 1'b1, 10, 3, 1);
    chk("asym_locked", locked, 1);

    // Input stops low: timeout 255 cycles after the last edge.
`ifdef PERIOD_METER_SYNC_EN
    exp_to = 248;
`else
    exp_to = 247;
`endif
    n = 0;
    while (timeout !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("timeout_delay", n, exp_to);
    chk("timeout_locked", locked, 0);
    repeat (20) tick();
    chk("timeout_sticky", timeout, 1);
    cyc(3, 7, 1'b0, 0, 0, 0);
    chk("timeout_after_arm", timeout, 1);
    cyc(3, 7, 1'b1, 10, 3, 0);
    chk("timeout_cleared", timeout, 0);
    drain("drain_timeout");

    // Reset mid-period, then minimum-period measurements.
    sig_in = 1'b1;
    repeat (2) tick();
    reset  = 1'b0;
    sig_in = 1'b0;
    #2;
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high_time", high_time, 0);
    chk("mid_rst_meas_valid", meas_valid, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_timeout", timeout, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    cyc(5, 5, 1'b0, 0, 0, 0);
    cyc(1, 1, 1'b1, 10, 5, 0);
    cyc(1, 1, 1'b1, 2, 1, 0);
    cyc(5, 5, 1'b1, 2, 1, 0);
    cyc(5, 5, 1'b1, 10, 5, 0);
    drain("drain_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
